// File: rtl/clk_ratio_pkg.sv
// Shared types and default widths for the clock-ratio measurement controller.
package clk_ratio_pkg;

  localparam int DEF_WIN_W   = 16;
  localparam int DEF_INC_W   = 4;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_RATIO_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/clk_ratio_ctrl_if.sv
// Sequencer-facing request/result bundle of the clock-ratio controller.
interface clk_ratio_ctrl_if
  import clk_ratio_pkg::*;
#(
  parameter int WIN_W   = DEF_WIN_W,
  parameter int INC_W   = DEF_INC_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RATIO_W = DEF_RATIO_W
) ();

  logic               start;
  logic               abort;
  logic [WIN_W-1:0]   window_cycles;
  logic [INC_W-1:0]   fast_inc;
  logic               busy;
  logic               done;
  logic               err_zero_win;
  logic [CNT_W-1:0]   fast_count;
  logic [RATIO_W-1:0] ratio;
  logic [WIN_W-1:0]   remainder;

  modport master (
    output start, abort, window_cycles, fast_inc,
    input  busy, done, err_zero_win, fast_count, ratio, remainder
  );

  modport slave (
    input  start, abort, window_cycles, fast_inc,
    output busy, done, err_zero_win, fast_count, ratio, remainder
  );

endinterface

// File: rtl/clk_ratio_div.sv
// Serial restoring divider: the load cycle already retires the first quotient bit,
// so div_done rises CNT_W-1 clocks after load and the quotient is final then.
module clk_ratio_div
  import clk_ratio_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             load,
  input  logic [CNT_W-1:0] dividend,
  input  logic [WIN_W-1:0] divisor,
  output logic [CNT_W-1:0] quotient,
  output logic [WIN_W-1:0] remainder,
  output logic             div_done
);

  localparam int STEP_W = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  quo_q, quo_d, cur_quo;
  logic [WIN_W-1:0]  rem_q, rem_d, cur_rem;
  logic [WIN_W-1:0]  dvs_q, dvs_d, cur_dvs;
  logic [STEP_W-1:0] step_q, step_d;
  logic              run_q, run_d;
  logic [WIN_W:0]    trial;

  // One shift-subtract step per clock while a division is in flight.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    step_d  = step_q;
    run_d   = run_q;
    cur_quo = load ? dividend : quo_q;
    cur_rem = load ? WIN_W'(0) : rem_q;
    cur_dvs = load ? divisor : dvs_q;
    trial   = {cur_rem, cur_quo[CNT_W-1]};
    if (load || (run_q && (step_q != STEP_W'(CNT_W)))) begin
      if (trial >= {1'b0, cur_dvs}) begin
        rem_d = WIN_W'(trial - {1'b0, cur_dvs});
        quo_d = {cur_quo[CNT_W-2:0], 1'b1};
      end else begin
        rem_d = trial[WIN_W-1:0];
        quo_d = {cur_quo[CNT_W-2:0], 1'b0};
      end
      dvs_d  = cur_dvs;
      run_d  = 1'b1;
      step_d = load ? STEP_W'(1) : (step_q + STEP_W'(1));
    end else begin
      run_d = run_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      quo_q  <= CNT_W'(0);
      rem_q  <= WIN_W'(0);
      dvs_q  <= WIN_W'(0);
      step_q <= STEP_W'(0);
      run_q  <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_done  = run_q && (step_q == STEP_W'(CNT_W));

endmodule

// File: rtl/clk_ratio_ctrl.sv
// Measurement sequencer: counts fast edges over an N-cycle window, divides by N,
// and reports the result with a one-cycle done pulse.
module clk_ratio_ctrl
  import clk_ratio_pkg::*;
#(
  parameter int WIN_W   = DEF_WIN_W,
  parameter int INC_W   = DEF_INC_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RATIO_W = DEF_RATIO_W
) (
  input logic             clk,
  input logic             reset_l,
  clk_ratio_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   n_q, n_d, ref_cnt_q, ref_cnt_d, rem_q, rem_d;
  logic [CNT_W-1:0]   acc_q, acc_d, fcnt_q, fcnt_d, acc_next_s;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               div_load_s, div_done_s;
  logic [CNT_W-1:0]   div_quo_s;
  logic [WIN_W-1:0]   div_rem_s;

  // Includes the current cycle's edges so the divider sees the final sum at load.
  assign acc_next_s = acc_q + {{(CNT_W-INC_W){1'b0}}, bus.fast_inc};

  // Next-state, accumulation and result capture.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    ref_cnt_d  = ref_cnt_q;
    acc_d      = acc_q;
    fcnt_d     = fcnt_q;
    ratio_d    = ratio_q;
    rem_d      = rem_q;
    err_d      = err_q;
    div_load_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          n_d       = bus.window_cycles;
          ref_cnt_d = WIN_W'(0);
          if (bus.window_cycles == WIN_W'(0)) begin
            state_d = DONE;
            err_d   = 1'b1;
            fcnt_d  = CNT_W'(0);
            ratio_d = RATIO_W'(0);
            rem_d   = WIN_W'(0);
          end else begin
            state_d = COUNT;
            err_d   = 1'b0;
            acc_d   = CNT_W'(0);
          end
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d     = acc_next_s;
          ref_cnt_d = ref_cnt_q + WIN_W'(1);
          if (ref_cnt_q == (n_q - WIN_W'(1))) begin
            state_d    = DIV;
            div_load_s = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      DIV: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (div_done_s) begin
          state_d = DONE;
          fcnt_d  = acc_q;
          ratio_d = RATIO_W'(div_quo_s);
          rem_d   = div_rem_s;
        end else begin
          state_d = DIV;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Controller state and result registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      n_q       <= WIN_W'(0);
      ref_cnt_q <= WIN_W'(0);
      acc_q     <= CNT_W'(0);
      fcnt_q    <= CNT_W'(0);
      ratio_q   <= RATIO_W'(0);
      rem_q     <= WIN_W'(0);
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      ref_cnt_q <= ref_cnt_d;
      acc_q     <= acc_d;
      fcnt_q    <= fcnt_d;
      ratio_q   <= ratio_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  clk_ratio_div #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) u_div (
    .clk       (clk),
    .reset_l   (reset_l),
    .load      (div_load_s),
    .dividend  (acc_next_s),
    .divisor   (n_q),
    .quotient  (div_quo_s),
    .remainder (div_rem_s),
    .div_done  (div_done_s)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_zero_win = err_q;
  assign bus.fast_count   = fcnt_q;
  assign bus.ratio        = ratio_q;
  assign bus.remainder    = rem_q;

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Directed bench for clk_ratio_ctrl: a table of measurements plus abort, held-start
// and mid-division reset sequences, all with hand-computed expectations.
module tb_clk_ratio_ctrl;

  localparam int WIN_W   = 16;
  localparam int INC_W   = 4;
  localparam int CNT_W   = 32;
  localparam int RATIO_W = 32;

  typedef struct packed {
    logic [15:0]      n;
    logic [3:0][3:0]  inc;
    logic [31:0]      fc;
    logic [31:0]      ratio;
    logic [15:0]      rem;
    logic             err;
  } vec_t;

  logic clk;
  logic reset_l;
  int   checks;
  int   errors;
  vec_t vecs [9];

  clk_ratio_ctrl_if #(.WIN_W(WIN_W), .INC_W(INC_W), .CNT_W(CNT_W), .RATIO_W(RATIO_W)) bus ();

  clk_ratio_ctrl #(.WIN_W(WIN_W), .INC_W(INC_W), .CNT_W(CNT_W), .RATIO_W(RATIO_W)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int i0, input int i1, input int i2, input int i3,
                              input int fc, input int ratio, input int rem, input bit err);
    vec_t v;
    v.n     = 16'(n);
    v.inc   = {4'(i3), 4'(i2), 4'(i1), 4'(i0)};
    v.fc    = 32'(fc);
    v.ratio = 32'(ratio);
    v.rem   = 16'(rem);
    v.err   = err;
    return v;
  endfunction

  // Start one measurement from IDLE, feed per-cycle increments, check latency and results.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int exp_lat;
    bit seen;
    bit busy_ok;
    lat     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    exp_lat = (v.n == 16'd0) ? 1 : int'(v.n) + CNT_W + 1;
    bus.window_cycles = v.n;
    bus.fast_inc      = 4'hF;
    bus.start         = 1'b1;
    while (!seen && lat < int'(v.n) + 100) begin
      tick();
      bus.start         = 1'b0;
      bus.window_cycles = 16'hBEEF;
      lat++;
      bus.fast_inc = (lat <= int'(v.n)) ? v.inc[(lat - 1) % 4] : 4'hF;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_busy"},   64'(busy_ok), 64'd1);
    chk({tag, "_lat"},    64'(lat), 64'(exp_lat));
    chk({tag, "_fc"},     64'(bus.fast_count), 64'(v.fc));
    chk({tag, "_ratio"},  64'(bus.ratio), 64'(v.ratio));
    chk({tag, "_rem"},    64'(bus.remainder), 64'(v.rem));
    chk({tag, "_err"},    64'(bus.err_zero_win), 64'(v.err));
    tick();
    chk({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle"},      64'(bus.busy), 64'd0);
  endtask

  // Abort a run after 'cyc' busy cycles and confirm nothing is reported.
  task automatic abort_run(input int n, input int inc, input int cyc, input string tag,
                           input int hfc, input int hratio, input int hrem);
    bit saw_done;
    saw_done          = 1'b0;
    bus.window_cycles = 16'(n);
    bus.fast_inc      = 4'(inc);
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < cyc; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    chk({tag, "_nodone"}, 64'(saw_done), 64'd0);
    chk({tag, "_fc_hold"},    64'(bus.fast_count), 64'(hfc));
    chk({tag, "_ratio_hold"}, 64'(bus.ratio), 64'(hratio));
    chk({tag, "_rem_hold"},   64'(bus.remainder), 64'(hrem));
  endtask

  initial begin
    int ndone;
    int pos [3];
    checks = 0;
    errors = 0;
    vecs[0] = mk(4,    3, 3, 3, 3,   12,    3,  0,   1'b0);
    vecs[1] = mk(3,    5, 2, 4, 0,   11,    3,  2,   1'b0);
    vecs[2] = mk(0,    0, 0, 0, 0,   0,     0,  0,   1'b1);
    vecs[3] = mk(2,    1, 1, 1, 1,   2,     1,  0,   1'b0);
    vecs[4] = mk(6,   15, 0, 9, 1,   40,    6,  4,   1'b0);
    vecs[5] = mk(5,    0, 0, 0, 0,   0,     0,  0,   1'b0);
    vecs[6] = mk(1,    9, 9, 9, 9,   9,     9,  0,   1'b0);
    vecs[7] = mk(7,    1, 0, 0, 0,   2,     0,  2,   1'b0);
    vecs[8] = mk(1000, 15, 15, 15, 14, 14750, 14, 750, 1'b0);

    reset_l           = 1'b0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.window_cycles = 16'd0;
    bus.fast_inc      = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_err",   64'(bus.err_zero_win), 64'd0);
    chk("rst_fc",    64'(bus.fast_count), 64'd0);
    chk("rst_ratio", 64'(bus.ratio), 64'd0);
    chk("rst_rem",   64'(bus.remainder), 64'd0);
    reset_l = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    abort_run(10, 2, 2,  "abort_count", 14750, 14, 750);
    abort_run(2,  5, 10, "abort_div",   14750, 14, 750);
    run_vec(mk(2, 7, 7, 7, 7, 14, 7, 0, 1'b0), "restart");

    // Start held high: back-to-back runs, no queuing of the extra requests.
    ndone             = 0;
    pos               = '{0, 0, 0};
    bus.window_cycles = 16'd1;
    bus.fast_inc      = 4'd9;
    bus.start         = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      tick();
      if (bus.done) begin
        if (ndone < 3) pos[ndone] = c;
        ndone++;
        chk("held_ratio", 64'(bus.ratio), 64'd9);
      end
    end
    chk("held_ndone", 64'(ndone), 64'd3);
    chk("held_pos0",  64'(pos[0]), 64'(CNT_W + 2));
    chk("held_pos1",  64'(pos[1]), 64'(2 * CNT_W + 5));
    chk("held_pos2",  64'(pos[2]), 64'(3 * CNT_W + 8));
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("held_abort_idle", 64'(bus.busy), 64'd0);

    // Short reset pulse in the middle of a division.
    bus.window_cycles = 16'd3;
    bus.fast_inc      = 4'd4;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #1;
    reset_l = 1'b0;
    #1;
    chk("arst_busy",  64'(bus.busy), 64'd0);
    chk("arst_done",  64'(bus.done), 64'd0);
    chk("arst_err",   64'(bus.err_zero_win), 64'd0);
    chk("arst_fc",    64'(bus.fast_count), 64'd0);
    chk("arst_ratio", 64'(bus.ratio), 64'd0);
    chk("arst_rem",   64'(bus.remainder), 64'd0);
    #2;
    reset_l = 1'b1;
    tick();
    chk("arst_idle", 64'(bus.busy), 64'd0);
    run_vec(mk(3, 4, 4, 4, 4, 12, 4, 0, 1'b0), "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
